// File: rtl/sseg_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package sseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t GLYPH_0 = 7'h40;
   localparam seg_t GLYPH_1 = 7'h79;
   localparam seg_t GLYPH_2 = 7'h24;
   localparam seg_t GLYPH_3 = 7'h30;
   localparam seg_t GLYPH_4 = 7'h19;
   localparam seg_t GLYPH_5 = 7'h12;
   localparam seg_t GLYPH_6 = 7'h02;
   localparam seg_t GLYPH_7 = 7'h78;
   localparam seg_t GLYPH_8 = 7'h00;
   localparam seg_t GLYPH_9 = 7'h10;
   localparam seg_t GLYPH_A = 7'h08;
   localparam seg_t GLYPH_B = 7'h03;
   localparam seg_t GLYPH_C = 7'h46;
   localparam seg_t GLYPH_D = 7'h21;
   localparam seg_t GLYPH_E = 7'h06;
   localparam seg_t GLYPH_F = 7'h0E;

   // b and d use the lower-case shapes so they differ from 8 and 0
   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      hex_to_seg = SEG_BLANK;
      case (nib)
         4'h0: hex_to_seg = GLYPH_0;
         4'h1: hex_to_seg = GLYPH_1;
         4'h2: hex_to_seg = GLYPH_2;
         4'h3: hex_to_seg = GLYPH_3;
         4'h4: hex_to_seg = GLYPH_4;
         4'h5: hex_to_seg = GLYPH_5;
         4'h6: hex_to_seg = GLYPH_6;
         4'h7: hex_to_seg = GLYPH_7;
         4'h8: hex_to_seg = GLYPH_8;
         4'h9: hex_to_seg = GLYPH_9;
         4'hA: hex_to_seg = GLYPH_A;
         4'hB: hex_to_seg = GLYPH_B;
         4'hC: hex_to_seg = GLYPH_C;
         4'hD: hex_to_seg = GLYPH_D;
         4'hE: hex_to_seg = GLYPH_E;
         4'hF: hex_to_seg = GLYPH_F;
         default: hex_to_seg = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// User-side data/strobe bundle and board-side pin outputs of the scan driver.
interface sseg_scan_driver_if
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);

   logic                      load;
   logic [4*NUM_DIGITS-1:0]   digits;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     blank;
   logic                      lz_en;

   logic [NUM_DIGITS-1:0]     an;
   seg_t                      seg;
   logic                      dp;
   logic                      frame_done;

   modport master (
      output load, digits, dp_in, blank, lz_en,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  load, digits, dp_in, blank, lz_en,
      output an, seg, dp, frame_done
   );

endinterface

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module sseg_hex_decoder
   import sseg_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);

   assign seg = hex_to_seg(nib);

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// double-buffered display data and optional leading-zero suppression.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000
)(
   input  logic               clk,
   input  logic               rst,
   sseg_scan_driver_if.slave  bus
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW     = 4*NUM_DIGITS;

   logic [TICK_W-1:0]     tick;
   logic [IDX_W-1:0]      idx;
   logic                  pending;

   logic [DW-1:0]         sh_digits;
   logic [NUM_DIGITS-1:0] sh_dp;
   logic [NUM_DIGITS-1:0] sh_blank;
   logic [DW-1:0]         act_digits;
   logic [NUM_DIGITS-1:0] act_dp;
   logic [NUM_DIGITS-1:0] act_blank;

   logic [NUM_DIGITS-1:0] an_q;
   seg_t                  seg_q;
   logic                  dp_q;

   logic                  slot_end;
   logic                  frame_end;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_run;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_off;
   seg_t                  cur_seg;
   logic [NUM_DIGITS-1:0] an_next;

   assign slot_end  = (tick == TICK_W'(SCAN_DIV-1));
   assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS-1));

   // Walk down from the top digit; a digit is dark while everything above
   // it (and itself) is a zero without a decimal point. Digit 0 is exempt.
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = NUM_DIGITS-1; i >= 1; i--) begin
         zero_run   = zero_run & (act_digits[i*4 +: 4] == 4'h0) & ~act_dp[i];
         lz_mask[i] = bus.lz_en & zero_run;
      end
   end

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_off = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib = act_digits[i*4 +: 4];
            cur_dp  = act_dp[i];
            cur_off = act_blank[i] | lz_mask[i];
         end
      end
   end

   sseg_hex_decoder u_dec (
      .nib (cur_nib),
      .seg (cur_seg)
   );

   always_comb begin
      an_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_next[i] = ~((idx == IDX_W'(i)) & ~cur_off);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick       <= '0;
         idx        <= '0;
         pending    <= 1'b0;
         sh_digits  <= '0;
         sh_dp      <= '0;
         sh_blank   <= '1;
         act_digits <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         tick <= slot_end ? '0 : tick + TICK_W'(1);
         if (slot_end) begin
            idx <= frame_end ? '0 : idx + IDX_W'(1);
         end

         if (bus.load) begin
            sh_digits <= bus.digits;
            sh_dp     <= bus.dp_in;
            sh_blank  <= bus.blank;
         end

         // A load landing on the frame boundary bypasses the shadow stage
         if (frame_end) begin
            pending <= 1'b0;
            if (bus.load) begin
               act_digits <= bus.digits;
               act_dp     <= bus.dp_in;
               act_blank  <= bus.blank;
            end else if (pending) begin
               act_digits <= sh_digits;
               act_dp     <= sh_dp;
               act_blank  <= sh_blank;
            end
         end else if (bus.load) begin
            pending <= 1'b1;
         end

         an_q  <= an_next;
         seg_q <= cur_off ? SEG_BLANK : cur_seg;
         dp_q  <= cur_off | ~cur_dp;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomised bench for sseg_scan_driver against a cycle-count based display model.
module tb_sseg_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int FR = ND*SD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   sseg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference state: cycles since reset, active/shadow display contents
   int              cyc;
   logic [3:0]      a_d [ND];
   logic [3:0]      s_d [ND];
   logic [ND-1:0]   a_dp, a_bl, s_dp, s_bl;
   bit              pend;
   logic [ND-1:0]   e_an;
   logic [6:0]      e_seg;
   logic            e_dp;
   int              an_low_cnt [ND];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void model_reset();
      cyc  = 0;
      pend = 0;
      for (int i = 0; i < ND; i++) begin
         a_d[i] = 4'h0;
         s_d[i] = 4'h0;
      end
      a_dp  = '0; s_dp = '0;
      a_bl  = '1; s_bl = '1;
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
   endfunction

   // highest "significant" digit position decides which digits are leading zeros
   function automatic void model_show(input int s, input bit lz);
      int  msd;
      bit  dark;
      msd = 0;
      for (int i = 0; i < ND; i++)
         if (a_d[i] != 4'h0 || a_dp[i]) msd = i;
      dark  = a_bl[s] || (lz && s > msd);
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (!dark) begin
         e_an[s] = 1'b0;
         e_seg   = glyph[a_d[s]];
         e_dp    = ~a_dp[s];
      end
   endfunction

   task automatic step(input bit r, input bit ld, input logic [15:0] d,
                       input logic [3:0] dpi, input logic [3:0] bl, input bit lz);
      bit fd;
      rst        = r;
      bus.load   = ld;
      bus.digits = d;
      bus.dp_in  = dpi;
      bus.blank  = bl;
      bus.lz_en  = lz;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         fd = (cyc % FR) == FR-1;
         model_show((cyc / SD) % ND, lz);
         if (fd) begin
            if (ld) begin
               for (int i = 0; i < ND; i++) a_d[i] = d[i*4 +: 4];
               a_dp = dpi; a_bl = bl;
            end else if (pend) begin
               a_d = s_d; a_dp = s_dp; a_bl = s_bl;
            end
            pend = 0;
         end else if (ld) begin
            pend = 1;
         end
         if (ld) begin
            for (int i = 0; i < ND; i++) s_d[i] = d[i*4 +: 4];
            s_dp = dpi; s_bl = bl;
         end
         cyc++;
      end
      #1;
      chk("an",         {28'h0, bus.an},          {28'h0, e_an});
      chk("seg",        {25'h0, bus.seg},         {25'h0, e_seg});
      chk("dp",         {31'h0, bus.dp},          {31'h0, e_dp});
      chk("frame_done", {31'h0, bus.frame_done},  {31'h0, ((cyc % FR) == FR-1)});
      for (int i = 0; i < ND; i++)
         if (bus.an[i] === 1'b0) an_low_cnt[i]++;
   endtask

   task automatic idle(input int n, input bit lz);
      for (int k = 0; k < n; k++) step(0, 0, 16'h0, 4'h0, 4'h0, lz);
   endtask

   task automatic idle_to(input int phase, input bit lz);
      int guard = 0;
      while ((cyc % FR) != phase && guard < 2*FR) begin
         step(0, 0, 16'h0, 4'h0, 4'h0, lz);
         guard++;
      end
   endtask

   task automatic clr_low_cnt();
      for (int i = 0; i < ND; i++) an_low_cnt[i] = 0;
   endtask

   logic [15:0] rd;
   bit          rlz;

   initial begin
      model_reset();
      clr_low_cnt();

      // held reset, then two dark frames
      for (int k = 0; k < 3; k++) step(1, 0, 16'h0, 4'h0, 4'h0, 0);
      chk("rst_an",  {28'h0, bus.an},  32'hF);
      chk("rst_seg", {25'h0, bus.seg}, 32'h7F);
      idle(2*FR, 0);
      chk("dark_frames_an_low", an_low_cnt[0] + an_low_cnt[1] + an_low_cnt[2] + an_low_cnt[3], 0);

      // basic load, committed at the next boundary
      step(0, 1, 16'h12AF, 4'h0, 4'h0, 0);
      idle(3*FR, 0);

      // mid-frame load at slot 1 must wait for the boundary
      idle_to(SD + 1, 0);
      step(0, 1, 16'h1234, 4'h0, 4'h0, 0);
      idle(2*FR, 0);

      // load coinciding with frame_done bypasses straight to active
      idle_to(FR-1, 0);
      step(0, 1, 16'h00C5, 4'h0, 4'h0, 0);
      idle(FR, 0);

      // leading-zero suppression cases
      idle_to(FR-1, 1);
      step(0, 1, 16'h0005, 4'h0, 4'h0, 1);
      clr_low_cnt();
      idle(2*FR, 1);
      chk("lz_0005_upper_dark", an_low_cnt[1] + an_low_cnt[2] + an_low_cnt[3], 0);
      chk("lz_0005_digit0_lit", (an_low_cnt[0] != 0), 1);
      idle_to(FR-1, 1);
      step(0, 1, 16'h0000, 4'h0, 4'h0, 1);
      idle(2*FR, 1);
      idle_to(FR-1, 1);
      step(0, 1, 16'h0000, 4'h4, 4'h0, 1);
      clr_low_cnt();
      idle(2*FR, 1);
      chk("lz_dp2_digit3_dark", an_low_cnt[3], 0);
      chk("lz_dp2_digit2_lit",  (an_low_cnt[2] != 0), 1);

      // reset at slot 2 with a pending load discards it
      idle_to(2*SD, 0);
      step(0, 1, 16'h9876, 4'h0, 4'h0, 0);
      step(1, 0, 16'h0, 4'h0, 4'h0, 0);
      clr_low_cnt();
      idle(2*FR, 0);
      chk("rst_pending_lost", an_low_cnt[0] + an_low_cnt[1] + an_low_cnt[2] + an_low_cnt[3], 0);

      // randomised traffic
      rlz = 0;
      for (int k = 0; k < 2000; k++) begin
         for (int i = 0; i < ND; i++)
            rd[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) rlz = ~rlz;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, rd,
              4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
              rlz);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
